// File: rtl/elevator_door_ctrl.sv
// Elevator door sequencer: open/hold/close strokes with stroke timeout and latched fault.
// Optional DOOR_REOPEN_EN: obstruction or open button while closing reverses the door.
//
// state   | meaning
// CLOSED  | door locked closed, car may move
// OPENING | motor driving open, stroke timer running
// HOLD    | door open, hold timer enabled
// RESTART | one idle cycle so the hold timer reloads
// CLOSING | motor driving closed, stroke timer running
// FAULT   | motors off, waiting for maintenance acknowledge
module elevator_door_ctrl #(
  parameter logic [27:0] MOVE_TIMEOUT = 28'd150000000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       car_stopped,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       open_limit,
  input  logic       closed_limit,
  input  logic       hold_done,
  input  logic       fault_clr,
  output logic       hold_en,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_closed,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_HOLD    = 3'd2,
    S_RESTART = 3'd3,
    S_CLOSING = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] move_cnt_q, move_cnt_d;
  logic [27:0] cnt_inc;
  logic        timeout_hit;
  logic        closing_paused;
  logic        hold_en_q, motor_open_q, motor_close_q, door_closed_q, fault_q;

  // The stroke times out on the edge that would complete the MOVE_TIMEOUT-th cycle.
  assign cnt_inc     = (move_cnt_q >= MOVE_TIMEOUT) ? MOVE_TIMEOUT : move_cnt_q + 28'd1;
  assign timeout_hit = (move_cnt_q + 28'd1) >= MOVE_TIMEOUT;

  always_comb begin
    state_d        = state_q;
    move_cnt_d     = '0;
    closing_paused = 1'b0;
    case (state_q)
      S_CLOSED: begin
        if (car_stopped && (arrive || open_btn)) state_d = S_OPENING;
      end
      S_OPENING: begin
        if (open_limit)       state_d = S_HOLD;
        else if (timeout_hit) state_d = S_FAULT;
        else                  move_cnt_d = cnt_inc;
      end
      S_HOLD: begin
        if (obstruct || open_btn)        state_d = S_RESTART;
        else if (close_btn || hold_done) state_d = S_CLOSING;
      end
      S_RESTART: state_d = S_HOLD;
      S_CLOSING: begin
`ifdef DOOR_REOPEN_EN
        if (obstruct || open_btn) state_d = S_OPENING;
        else if (closed_limit)    state_d = S_CLOSED;
        else if (timeout_hit)     state_d = S_FAULT;
        else                      move_cnt_d = cnt_inc;
`else
        // Obstruction pauses the stroke: motor off, timer frozen.
        if (closed_limit) state_d = S_CLOSED;
        else if (obstruct) begin
          closing_paused = 1'b1;
          move_cnt_d     = move_cnt_q;
        end
        else if (timeout_hit) state_d = S_FAULT;
        else                  move_cnt_d = cnt_inc;
`endif
      end
      S_FAULT: begin
        if (fault_clr) state_d = closed_limit ? S_CLOSED : S_OPENING;
      end
      default: state_d = S_FAULT;
    endcase

    if (state_q != S_FAULT && state_q != S_CLOSED && !car_stopped) begin
      state_d        = S_FAULT;
      move_cnt_d     = '0;
      closing_paused = 1'b0;
    end
    if (state_q != S_FAULT && open_limit && closed_limit) begin
      state_d        = S_FAULT;
      move_cnt_d     = '0;
      closing_paused = 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_CLOSED;
      move_cnt_q    <= '0;
      hold_en_q     <= 1'b0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      door_closed_q <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      move_cnt_q    <= move_cnt_d;
      hold_en_q     <= (state_d == S_HOLD);
      motor_open_q  <= (state_d == S_OPENING);
      motor_close_q <= (state_d == S_CLOSING) && !closing_paused;
      door_closed_q <= (state_d == S_CLOSED);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign hold_en     = hold_en_q;
  assign motor_open  = motor_open_q;
  assign motor_close = motor_close_q;
  assign door_closed = door_closed_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: doc/elevator_door_ctrl.md
ELEVATOR_DOOR_CTRL -- requirements
Module: elevator_door_ctrl

Interface
REQ-001 Parameter: MOVE_TIMEOUT, default 28'd150000000, max clk_50M cycles allowed for one door open or close stroke (3 s at 50 MHz).
REQ-002 clk_50M  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 car_stopped  input  1  car level at a floor, doors permitted to move.
REQ-005 arrive  input  1  one-cycle pulse, car has just stopped at a served floor.
REQ-006 open_btn  input  1  cabin/landing door-open button, level.
REQ-007 close_btn  input  1  cabin door-close button, level.
REQ-008 obstruct  input  1  door-edge/light-curtain obstruction, level.
REQ-009 open_limit  input  1  door fully-open limit switch.
REQ-010 closed_limit  input  1  door fully-closed limit switch.
REQ-011 hold_done  input  1  done flag from the 5 s hold timer (delay_5s_done).
REQ-012 fault_clr  input  1  one-cycle pulse, maintenance fault acknowledge.
REQ-013 hold_en  output  1  enable to the 5 s hold timer.
REQ-014 motor_open  output  1  drive door motor in open direction.
REQ-015 motor_close  output  1  drive door motor in close direction.
REQ-016 door_closed  output  1  door locked closed, car may move.
REQ-017 fault  output  1  door fault latched.
REQ-018 state  output  3  current state encoding, debug.

Function
REQ-019 States SHALL be CLOSED=0, OPENING=1, HOLD=2, RESTART=3, CLOSING=4, FAULT=5; codes 6-7 SHALL go to FAULT next cycle.
REQ-020 All outputs SHALL be registered and decoded from the state register: motor_open=OPENING; motor_close=CLOSING (see REQ-031); hold_en=HOLD; door_closed=CLOSED; fault=FAULT.
REQ-021 CLOSED -> OPENING when car_stopped and (arrive or open_btn); otherwise stay.
REQ-022 OPENING -> HOLD when open_limit; else -> FAULT when move_cnt reaches MOVE_TIMEOUT; open_limit wins if both in same cycle.
REQ-023 HOLD priority: obstruct or open_btn -> RESTART; else close_btn or hold_done -> CLOSING.
REQ-024 RESTART -> HOLD unconditionally after one cycle, guaranteeing hold_en low for one cycle so the hold timer reloads to zero.
REQ-025 CLOSING -> CLOSED when closed_limit; else -> FAULT at move_cnt == MOVE_TIMEOUT; closed_limit wins if both.
REQ-026 FAULT -> CLOSED on fault_clr when closed_limit, -> OPENING on fault_clr otherwise; all motors off while in FAULT.
REQ-027 Any state except FAULT SHALL go to FAULT when open_limit and closed_limit are both high (sensor conflict); this has highest priority.
REQ-028 move_cnt (28 bits) SHALL clear on entry to OPENING or CLOSING, increment each cycle in those states, saturate at MOVE_TIMEOUT, and clear in all other states.
REQ-029 car_stopped low in any state other than CLOSED or FAULT SHALL force FAULT.

Reset
REQ-030 On rst_n low: state=CLOSED, move_cnt=0, hold_en=0, motor_open=0, motor_close=0, door_closed=1, fault=0; reset mid-stroke SHALL stop the motor in the same asynchronous event.

Configuration
REQ-031 Macro DOOR_REOPEN_EN: when defined, obstruct or open_btn in CLOSING SHALL go to OPENING next cycle (move_cnt reset); when undefined, open_btn in CLOSING SHALL be ignored and obstruct SHALL hold CLOSING with motor_close=0 and move_cnt frozen until obstruct clears.

Verification
REQ-032 MOVE_TIMEOUT=20; arrive with car_stopped, open_limit after 5 cycles -> OPENING, HOLD, hold_en=1; hold_done -> CLOSING; closed_limit -> CLOSED, door_closed=1.
REQ-033 In HOLD pulse open_btn -> one RESTART cycle with hold_en=0, then HOLD with hold_en=1.
REQ-034 OPENING with open_limit never asserted -> FAULT after exactly 20 cycles, motor_open=0, fault=1; fault_clr with closed_limit=0 -> OPENING.
REQ-035 CLOSING, obstruct for 4 cycles -> with DOOR_REOPEN_EN: OPENING next cycle; without: motor_close=0, move_cnt unchanged for 4 cycles, then resume.
REQ-036 open_limit and closed_limit both high in HOLD -> FAULT next cycle; rst_n low mid-CLOSING -> CLOSED, motor_close=0 immediately.
